// File: rtl/instrmem_pkg.sv
// Shared instruction-memory definitions: loader FSM states and memory geometry.
// The CPU top uses the same geometry constants.
package instrmem_pkg;

  localparam int unsigned IMEM_A_WIDTH   = 12;
  localparam int unsigned IMEM_BYTES     = 4096;
  localparam int unsigned IMEM_D_WIDTH   = 8;
  localparam int unsigned IMEM_EXT_WIDTH = 32;
  localparam int unsigned IMEM_LANES     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-wide instruction RAM: one synchronous byte write port and one
// combinational little-endian word read port whose lanes wrap modulo the depth.
module instr_byte_ram
  import instrmem_pkg::*;
#(
  parameter int unsigned D_WIDTH = IMEM_D_WIDTH,
  parameter int unsigned A_WIDTH = IMEM_A_WIDTH
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [A_WIDTH-1:0]            waddr_i,
  input  logic [D_WIDTH-1:0]            wdata_i,
  input  logic [A_WIDTH-1:0]            raddr_i,
  output logic [IMEM_LANES*D_WIDTH-1:0] rdata_c_o
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Lane k reads byte (raddr + k) with the sum truncated to A_WIDTH bits.
  always_comb begin
    rdata_c_o = '0;
    for (int k = 0; k < IMEM_LANES; k++) begin
      rdata_c_o[k*D_WIDTH +: D_WIDTH] = mem_q[A_WIDTH'(raddr_i + A_WIDTH'(k))];
    end
  end

endmodule

// File: rtl/instrmem_loader.sv
// Instruction-memory writer: fills the byte RAM from a valid/ready stream after
// load_start, holds the CPU while loading, and serves the CPU fetch port.
module instrmem_loader
  import instrmem_pkg::*;
#(
  parameter int unsigned D_WIDTH   = IMEM_D_WIDTH,
  parameter int unsigned A_WIDTH   = IMEM_A_WIDTH,
  parameter int unsigned EXT_WIDTH = IMEM_EXT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [A_WIDTH:0]     load_len,
  input  logic [D_WIDTH-1:0]   s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 busy,
  output logic                 cpu_hold,
  output logic                 done,
  output logic [A_WIDTH:0]     load_count,
  input  logic [EXT_WIDTH-1:0] A,
  output logic [EXT_WIDTH-1:0] RD
);

  localparam int unsigned CW = A_WIDTH + 1;
  localparam logic [CW-1:0] MAX_LEN = {1'b1, {A_WIDTH{1'b0}}};

  loader_state_t state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_ready_q, busy_q, done_q;
  logic          accept_c;
  logic          we_c;
  logic [IMEM_LANES*D_WIDTH-1:0] rdata_c;
  logic          unused_a;

  assign accept_c = s_valid && s_ready_q;
  // A byte presented alongside rst is not written.
  assign we_c     = accept_c && !rst;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          len_d   = (load_len > MAX_LEN) ? MAX_LEN : load_len;
          cnt_d   = '0;
          state_d = (load_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept_c) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status flags are registered straight from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      s_ready_q <= (state_d == LOAD);
      busy_q    <= (state_d == LOAD);
      done_q    <= (state_d == DONE);
    end
  end

  instr_byte_ram #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_ram (
    .clk       (clk),
    .we_i      (we_c),
    .waddr_i   (cnt_q[A_WIDTH-1:0]),
    .wdata_i   (s_data),
    .raddr_i   (A[A_WIDTH-1:0]),
    .rdata_c_o (rdata_c)
  );

  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign cpu_hold   = busy_q;
  assign done       = done_q;
  assign load_count = cnt_q;
  assign RD         = EXT_WIDTH'(rdata_c);
  assign unused_a   = ^A[EXT_WIDTH-1:A_WIDTH];

endmodule
